answer_gen_lcg: RTL
===================

Name: answer_gen_lcg

Overview:
Parametrised answer generator for the number-guessing game. Produces NUM_DIGITS digits, each in 1..DIGIT_MAX, from a 32-bit LCG (glibc constants) and commits the packed answer atomically, with a one-cycle write_enable pulse to the answer store. Replaces the fixed 8×4-bit generator. Adds reset, seed loading, a busy/valid handshake and an optional no-repeat-digit mode. Sits between the debounced "new game" control and the answer register/compare logic.

Parameters:
NUM_DIGITS, 8, digits per answer (1..16)
DIGIT_W, 4, bits per digit; DIGIT_MAX < 2**DIGIT_W
DIGIT_MAX, 8, largest digit value; digits range 1..DIGIT_MAX
LCG_A, 1103515245, LCG multiplier
LCG_C, 12345, LCG increment
SEED, 1, LCG state after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
change_answer  in  1  request a new answer; synchronous, rising edge detected internally
seed_load  in  1  load seed_value into the LCG state (IDLE only)
seed_value  in  32  seed for seed_load
answer  out  NUM_DIGITS*DIGIT_W  packed answer; digit k at [k*DIGIT_W +: DIGIT_W]
answer_valid  out  1  high once the first answer has been committed
busy  out  1  generation in progress
write_enable  out  1  one-cycle pulse in the cycle answer changes

Behaviour:
- Reset (async): state=SEED, FSM=IDLE, answer=0, answer_valid=0, busy=0, write_enable=0, edge-detect flop=0.
- LCG: state_next = (LCG_A*state + LCG_C) mod 2**32. The LCG steps only on a GEN cycle, never while idle, so the sequence is deterministic from the seed.
- Draw value r = state_next[30:16]. Candidate digit = (r mod DIGIT_MAX) + 1, truncated to DIGIT_W.
- FSM states:
  - IDLE: on a change_answer rising edge (current=1, previous=0), clear the digit index, go to GEN, busy=1 from the next cycle. seed_load=1 in IDLE loads seed_value. If seed_load and the edge occur together, load the seed first; GEN then starts from the new seed.
  - GEN: one LCG step per cycle. Each cycle the candidate is written into a shadow register at index idx, then idx++. After the draw at idx=NUM_DIGITS-1, go to COMMIT.
  - COMMIT: answer <= shadow, write_enable=1 for this single cycle, answer_valid=1, busy=0, then IDLE.
- Latency without the feature: edge at cycle n; GEN spans cycles n+1..n+NUM_DIGITS; write_enable is high at n+NUM_DIGITS+1.
- answer never shows partial digits; it changes only in COMMIT.
- change_answer edges while busy are ignored and not queued. A held-high change_answer triggers only once. seed_load while busy is ignored.
- Reset mid-GEN aborts the generation: no write_enable, and all reset values are restored.

Optional Feature:
UNIQUE_DIGITS_EN. When defined, a candidate equal to any already-accepted digit in the current answer is rejected: the LCG still steps, idx does not advance. Acceptance uses a DIGIT_MAX-bit used-mask, cleared on entering GEN. Elaboration error if NUM_DIGITS > DIGIT_MAX. Latency becomes variable (at least NUM_DIGITS GEN cycles).
When undefined, repeats are allowed, there is no mask logic, and latency is fixed.

Decomposition:
- Shared package answer_pkg: FSM state enum (IDLE, GEN, COMMIT), LCG default constants, and a function digit_from_state(state, DIGIT_MAX).
- One natural sub-module: lcg32 (state register, step enable, load, next-state output), reusable elsewhere. FSM, shadow register and mask stay in the top.

Test Plan:
- Reset, default params, then a change_answer pulse → write_enable exactly 9 cycles after the edge. answer=0x43444277 (digits 7,7,2,4,4,4,3,4 from draws 16838, 5758, 10113, 17515, 31051, 5627, 23010, 7419). answer_valid=1, busy low again.
- change_answer held high 40 cycles, plus extra pulses during busy → exactly one write_enable, answer unchanged afterwards.
- seed_load with seed_value=1 after one generation, then request again → identical answer 0x43444277. seed_load asserted while busy → no effect.
- rst asserted at GEN cycle 4 → no write_enable, answer=0, answer_valid=0. Next request reproduces 0x43444277.
- UNIQUE_DIGITS_EN, NUM_DIGITS=4, seed 1 → draws 7,7r,2,4,4r,4r,3 give answer=0x3427 after 7 GEN cycles, write_enable on the following cycle.
- Sweep DIGIT_MAX=9, NUM_DIGITS=6, 1000 requests → every digit in 1..9, and no digit repeats when UNIQUE_DIGITS_EN is defined.

Source files
------------

// File: rtl/answer_pkg.sv
// Shared types, LCG defaults and digit mapping for the answer generator.
package answer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GEN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [31:0] LCG_A_DEF = 32'd1103515245;
  localparam logic [31:0] LCG_C_DEF = 32'd12345;
  localparam logic [31:0] SEED_DEF  = 32'd1;

  function automatic logic [15:0] digit_from_state(
    input logic [31:0] s,
    input int unsigned dmax
  );
    logic [31:0] r;
    r = {17'd0, s[30:16]};
    return 16'((r % dmax) + 32'd1);
  endfunction

endpackage

// File: rtl/lcg32.sv
// 32-bit linear congruential generator with load and step enable.
module lcg32
  import answer_pkg::*;
#(
  parameter logic [31:0] A    = LCG_A_DEF,
  parameter logic [31:0] C    = LCG_C_DEF,
  parameter logic [31:0] SEED = SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_step,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  output logic [31:0] o_next
);

  logic [31:0] r_state;

  assign o_next = A * r_state + C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_step) begin
      r_state <= o_next;
    end
  end

endmodule

// File: rtl/answer_gen_lcg.sv
// LCG-driven answer generator with atomic commit.
// Define UNIQUE_DIGITS_EN to reject repeated digits within one answer.
module answer_gen_lcg
  import answer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned DIGIT_MAX  = 8,
  parameter logic [31:0] LCG_A      = LCG_A_DEF,
  parameter logic [31:0] LCG_C      = LCG_C_DEF,
  parameter logic [31:0] SEED       = SEED_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          change_answer,
  input  logic                          seed_load,
  input  logic [31:0]                   seed_value,
  output logic [NUM_DIGITS*DIGIT_W-1:0] answer,
  output logic                          answer_valid,
  output logic                          busy,
  output logic                          write_enable
);

  localparam int unsigned AW = NUM_DIGITS * DIGIT_W;
  localparam int unsigned IW = $clog2(NUM_DIGITS + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  if (DIGIT_MAX >= (1 << DIGIT_W)) begin : g_dw_err
    $error("DIGIT_MAX does not fit in DIGIT_W bits");
  end

  state_t          r_state;
  state_t          w_state_nx;
  logic            r_prev;
  logic [IW-1:0]   r_idx;
  logic [AW-1:0]   r_shadow;
  logic [AW-1:0]   r_answer;
  logic [AW-1:0]   w_merged;
  logic            r_valid;
  logic [31:0]     w_lcg_next;
  logic [DIGIT_W-1:0] w_cand;
  logic            w_edge;
  logic            w_step;
  logic            w_load;
  logic            w_start;
  logic            w_accept;
  logic            w_last;

  assign w_edge  = change_answer & ~r_prev;
  assign w_step  = (r_state == GEN);
  assign w_load  = seed_load & (r_state == IDLE);
  assign w_start = w_edge & (r_state == IDLE);
  assign w_cand  = DIGIT_W'(digit_from_state(w_lcg_next, DIGIT_MAX));
  assign w_last  = w_step & w_accept & (r_idx == LAST);

  lcg32 #(
    .A    (LCG_A),
    .C    (LCG_C),
    .SEED (SEED)
  ) u_lcg (
    .clk    (clk),
    .rst    (rst),
    .i_step (w_step),
    .i_load (w_load),
    .i_seed (seed_value),
    .o_next (w_lcg_next)
  );

`ifdef UNIQUE_DIGITS_EN
  if (NUM_DIGITS > DIGIT_MAX) begin : g_nd_err
    $error("NUM_DIGITS exceeds DIGIT_MAX with unique digits");
  end

  logic [DIGIT_MAX-1:0] r_mask;
  logic [DIGIT_MAX-1:0] w_bit;

  assign w_bit    = DIGIT_MAX'(1) << (w_cand - DIGIT_W'(1));
  assign w_accept = ~|(r_mask & w_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else if (w_start) begin
      r_mask <= '0;
    end else if (w_step && w_accept) begin
      r_mask <= r_mask | w_bit;
    end
  end
`else
  assign w_accept = 1'b1;
`endif

  always_comb begin
    w_merged = r_shadow;
    if (r_idx <= LAST) begin
      w_merged[r_idx*DIGIT_W +: DIGIT_W] = w_cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_edge) w_state_nx = GEN;
      GEN:     if (w_last) w_state_nx = COMMIT;
      COMMIT:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state == GEN);
    write_enable = (r_state == COMMIT);
  end

  // answer is loaded on the way into COMMIT so it is stable while write_enable is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev   <= 1'b0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_answer <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_prev <= change_answer;
      if (w_start) begin
        r_idx <= '0;
      end else if (w_step && w_accept) begin
        r_shadow <= w_merged;
        r_idx    <= r_idx + IW'(1);
      end
      if (w_last) begin
        r_answer <= w_merged;
        r_valid  <= 1'b1;
      end
    end
  end

  assign answer       = r_answer;
  assign answer_valid = r_valid;

endmodule
